// File: rtl/tmu_writer.sv
// Producer side of the TMU write interface. Upstream samples tagged for the
// CORDIC or PID channel are queued in a small FIFO and issued strictly in
// order as one-cycle write-enable pulses with the matching data word. The
// data word is registered at the same edge as the enable and then held, so
// the TMU can capture it one cycle after it registers the enable.
module tmu_writer #(
  parameter int DW    = 12,
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     s_sel,
  input  logic [DW-1:0]            s_data,
  input  logic                     flush,
  output logic [DW-1:0]            data_cordic_in,
  output logic                     write_enablecordic,
  output logic [DW-1:0]            data_pid_in,
  output logic                     write_enablepid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(GAP + 1);

  // One queued sample: channel tag (0 = CORDIC, 1 = PID) plus the data word.
  typedef struct packed {
    logic          sel;
    logic [DW-1:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            s_ready_q, s_ready_d;
  logic [CW-1:0]   cool_c_q, cool_c_d;
  logic [CW-1:0]   cool_p_q, cool_p_d;
  logic [DW-1:0]   data_c_q, data_c_d;
  logic [DW-1:0]   data_p_q, data_p_d;
  logic            en_c_q, en_c_d;
  logic            en_p_q, en_p_d;
  logic            busy_q, busy_d;

  entry_t          head;
  logic            head_cool_zero;
  logic            push;
  logic            issue;

  // Next-state logic: flush wins over push and issue; the head only issues
  // when its own channel has finished cooling down (head-of-line blocking).
  always_comb begin
    head           = mem_q[rd_ptr_q];
    head_cool_zero = head.sel ? (cool_p_q == '0) : (cool_c_q == '0);
    push           = s_valid && s_ready_q && !flush;
    issue          = !flush && (level_q != '0) && head_cool_zero;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    data_c_d = data_c_q;
    data_p_d = data_p_q;
    en_c_d   = 1'b0;
    en_p_d   = 1'b0;
    cool_c_d = (cool_c_q != '0) ? cool_c_q - CW'(1) : cool_c_q;
    cool_p_d = (cool_p_q != '0) ? cool_p_q - CW'(1) : cool_p_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{sel: s_sel, data: s_data};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    if (issue) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (head.sel) begin
        en_p_d   = 1'b1;
        data_p_d = head.data;
        cool_p_d = CW'(GAP);
      end else begin
        en_c_d   = 1'b1;
        data_c_d = head.data;
        cool_c_d = CW'(GAP);
      end
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else if (push && !issue) begin
      level_d = level_q + LW'(1);
    end else if (issue && !push) begin
      level_d = level_q - LW'(1);
    end

    s_ready_d = (level_d != LW'(DEPTH));
    busy_d    = (level_d != '0) || (cool_c_d != '0) || (cool_p_d != '0);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      s_ready_q <= 1'b0;
      cool_c_q  <= '0;
      cool_p_q  <= '0;
      data_c_q  <= '0;
      data_p_q  <= '0;
      en_c_q    <= 1'b0;
      en_p_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      s_ready_q <= s_ready_d;
      cool_c_q  <= cool_c_d;
      cool_p_q  <= cool_p_d;
      data_c_q  <= data_c_d;
      data_p_q  <= data_p_d;
      en_c_q    <= en_c_d;
      en_p_q    <= en_p_d;
      busy_q    <= busy_d;
    end
  end

  assign s_ready            = s_ready_q;
  assign level              = level_q;
  assign busy               = busy_q;
  assign data_cordic_in     = data_c_q;
  assign write_enablecordic = en_c_q;
  assign data_pid_in        = data_p_q;
  assign write_enablepid    = en_p_q;

endmodule

// File: tb/tb_tmu_writer.sv
// Bench for tmu_writer: two instances (GAP=1 and GAP=3) share one stimulus
// stream; each is compared every cycle against a queue-based model that
// tracks the cycle of the last pulse per channel.
module tb_tmu_writer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sValid;
  logic        sSel;
  logic [11:0] sData;
  logic        flush;

  logic        rdy   [2];
  logic        enc   [2];
  logic        enp   [2];
  logic        busyO [2];
  logic [11:0] dc    [2];
  logic [11:0] dp    [2];
  logic [2:0]  lvl   [2];

  int compared   = 0;
  int mismatched = 0;

  // Model state, one set per instance
  int          gapOf [2] = '{1, 3};
  logic [12:0] mq    [2][$];
  int          lastIssue [2][2];
  logic        mEn   [2][2];
  logic [11:0] mData [2][2];
  logic        mRdy  [2];
  int          cycleN = 0;
  logic        stalled = 1'b0;
  int          plog  [2][2][$];

  always #5 clk = ~clk;

  tmu_writer #(.DW(12), .DEPTH(4), .GAP(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .s_valid(sValid), .s_ready(rdy[0]),
    .s_sel(sSel), .s_data(sData), .flush(flush),
    .data_cordic_in(dc[0]), .write_enablecordic(enc[0]),
    .data_pid_in(dp[0]), .write_enablepid(enp[0]),
    .level(lvl[0]), .busy(busyO[0])
  );

  tmu_writer #(.DW(12), .DEPTH(4), .GAP(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .s_valid(sValid), .s_ready(rdy[1]),
    .s_sel(sSel), .s_data(sData), .flush(flush),
    .data_cordic_in(dc[1]), .write_enablecordic(enc[1]),
    .data_pid_in(dp[1]), .write_enablepid(enp[1]),
    .level(lvl[1]), .busy(busyO[1])
  );

  task automatic cmp(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s dut%0d: observed %0h expected %0h at cycle %0d", tag, k, obs, expv, cycleN);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic modelStep();
    logic [12:0] e;
    logic        pushOk;
    int          c;
    stalled = rstn && sValid && (!mRdy[0] || !mRdy[1]);
    for (int k = 0; k < 2; k++) begin
      if (!rstn) begin
        mq[k].delete();
        for (int j = 0; j < 2; j++) begin
          lastIssue[k][j] = -100;
          mEn[k][j]       = 1'b0;
          mData[k][j]     = '0;
        end
        mRdy[k] = 1'b0;
      end else begin
        pushOk    = sValid && mRdy[k] && !flush;
        mEn[k][0] = 1'b0;
        mEn[k][1] = 1'b0;
        if (flush) begin
          mq[k].delete();
        end else begin
          if (mq[k].size() > 0) begin
            e = mq[k][0];
            c = int'(e[12]);
            if (cycleN - lastIssue[k][c] >= gapOf[k] + 1) begin
              void'(mq[k].pop_front());
              mEn[k][c]       = 1'b1;
              mData[k][c]     = e[11:0];
              lastIssue[k][c] = cycleN;
            end
          end
          if (pushOk) mq[k].push_back({sSel, sData});
        end
        mRdy[k] = (mq[k].size() != 4);
      end
    end
  endtask

  function automatic logic modelBusy(input int k);
    return (mq[k].size() != 0) ||
           (cycleN - lastIssue[k][0] < gapOf[k]) ||
           (cycleN - lastIssue[k][1] < gapOf[k]);
  endfunction

  task automatic checkOutput();
    for (int k = 0; k < 2; k++) begin
      cmp("s_ready", k, 32'(rdy[k]), 32'(mRdy[k]));
      cmp("level", k, 32'(lvl[k]), 32'(mq[k].size()));
      cmp("busy", k, 32'(busyO[k]), 32'(modelBusy(k)));
      cmp("we_cordic", k, 32'(enc[k]), 32'(mEn[k][0]));
      cmp("we_pid", k, 32'(enp[k]), 32'(mEn[k][1]));
      cmp("data_cordic", k, 32'(dc[k]), 32'(mData[k][0]));
      cmp("data_pid", k, 32'(dp[k]), 32'(mData[k][1]));
      if (enc[k] === 1'b1) plog[k][0].push_back(cycleN);
      if (enp[k] === 1'b1) plog[k][1].push_back(cycleN);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic sel, input logic [11:0] d,
                               input logic fl, input logic rst);
    sValid = v;
    sSel   = sel;
    sData  = d;
    flush  = fl;
    rstn   = rst;
    @(posedge clk);
    cycleN++;
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, sSel, sData, 1'b0, 1'b1);
  endtask

  // Present one sample and hold it until both instances have taken it
  task automatic sendSample(input logic sel, input logic [11:0] d);
    logic done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      applyStimulus(1'b1, sel, d, 1'b0, 1'b1);
      if (!stalled) done = 1'b1;
    end
    cmp("send_accept", 0, 32'(done), 32'd1);
  endtask

  task automatic clearLogs();
    for (int k = 0; k < 2; k++) begin
      plog[k][0].delete();
      plog[k][1].delete();
    end
  endtask

  task automatic expectPulses(input string tag, input int k, input int c, input int num,
                              input int e0, input int e1, input int e2);
    int ev;
    cmp({tag, "_count"}, k, 32'(plog[k][c].size()), 32'(num));
    for (int i = 0; i < num; i++) begin
      ev = (i == 0) ? e0 : (i == 1) ? e1 : e2;
      if (i < plog[k][c].size()) cmp({tag, "_cycle"}, k, 32'(plog[k][c][i]), 32'(ev));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: bench did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int t0;
    logic        rv, rs, rf, rsel;
    logic [11:0] rd;

    sValid = 1'b0; sSel = 1'b0; sData = '0; flush = 1'b0; rstn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mRdy[k] = 1'b0;
      for (int j = 0; j < 2; j++) begin
        lastIssue[k][j] = -100; mEn[k][j] = 1'b0; mData[k][j] = '0;
      end
    end

    $display("[TB] reset");
    applyStimulus(1'b0, 1'b0, 12'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 12'h0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) cmp("reset_ready", k, 32'(rdy[k]), 32'd0);
    idle(1);
    for (int k = 0; k < 2; k++) cmp("release_ready", k, 32'(rdy[k]), 32'd1);

    $display("[TB] single CORDIC sample");
    clearLogs();
    sendSample(1'b0, 12'h5A3);
    t0 = cycleN;
    idle(5);
    for (int k = 0; k < 2; k++) begin
      expectPulses("single_c", k, 0, 1, t0 + 1, 0, 0);
      expectPulses("single_p", k, 1, 0, 0, 0, 0);
      cmp("single_data", k, 32'(dc[k]), 32'h5A3);
      cmp("single_pid_data", k, 32'(dp[k]), 32'h0);
    end

    $display("[TB] three PID samples");
    clearLogs();
    sendSample(1'b1, 12'h001);
    t0 = cycleN;
    sendSample(1'b1, 12'h002);
    sendSample(1'b1, 12'h003);
    idle(12);
    expectPulses("pid3", 0, 1, 3, t0 + 1, t0 + 3, t0 + 5);
    expectPulses("pid3", 1, 1, 3, t0 + 1, t0 + 5, t0 + 9);
    for (int k = 0; k < 2; k++) cmp("pid3_data", k, 32'(dp[k]), 32'h003);

    $display("[TB] interleaved channels");
    clearLogs();
    sendSample(1'b0, 12'h100);
    t0 = cycleN;
    sendSample(1'b1, 12'h200);
    sendSample(1'b0, 12'h300);
    idle(10);
    expectPulses("ilv_c", 0, 0, 2, t0 + 1, t0 + 3, 0);
    expectPulses("ilv_p", 0, 1, 1, t0 + 2, 0, 0);
    expectPulses("ilv_c", 1, 0, 2, t0 + 1, t0 + 5, 0);
    expectPulses("ilv_p", 1, 1, 1, t0 + 2, 0, 0);

    $display("[TB] head-of-line blocking");
    clearLogs();
    sendSample(1'b0, 12'h400);
    t0 = cycleN;
    sendSample(1'b0, 12'h500);
    sendSample(1'b1, 12'h600);
    idle(10);
    expectPulses("hol_c", 1, 0, 2, t0 + 1, t0 + 5, 0);
    expectPulses("hol_p", 1, 1, 1, t0 + 6, 0, 0);
    expectPulses("hol_c", 0, 0, 2, t0 + 1, t0 + 3, 0);
    expectPulses("hol_p", 0, 1, 1, t0 + 4, 0, 0);

    $display("[TB] fill and backpressure");
    for (int i = 1; i <= 7; i++) sendSample(1'b0, 12'(12'h800 + i));
    idle(30);
    for (int k = 0; k < 2; k++) cmp("fill_last_data", k, 32'(dc[k]), 32'h807);

    $display("[TB] flush");
    clearLogs();
    for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 1'b0, 12'(12'h700 + i), 1'b0, 1'b1);
    t0 = cycleN - 5;
    applyStimulus(1'b0, 1'b0, 12'h706, 1'b1, 1'b1);
    idle(10);
    for (int k = 0; k < 2; k++) cmp("flush_level", k, 32'(lvl[k]), 32'd0);
    expectPulses("flush_c", 0, 0, 3, t0 + 1, t0 + 3, t0 + 5);
    expectPulses("flush_c", 1, 0, 2, t0 + 1, t0 + 5, 0);
    cmp("flush_data", 0, 32'(dc[0]), 32'h703);
    cmp("flush_data", 1, 32'(dc[1]), 32'h702);

    $display("[TB] reset mid-operation");
    sendSample(1'b0, 12'h901);
    sendSample(1'b0, 12'h902);
    sendSample(1'b1, 12'h903);
    applyStimulus(1'b0, 1'b0, 12'h0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      cmp("midrst_level", k, 32'(lvl[k]), 32'd0);
      cmp("midrst_data", k, 32'(dc[k]), 32'd0);
    end
    idle(1);
    sendSample(1'b1, 12'hA55);
    idle(4);
    for (int k = 0; k < 2; k++) begin
      cmp("post_rst_pid", k, 32'(dp[k]), 32'hA55);
      cmp("post_rst_cordic", k, 32'(dc[k]), 32'h0);
    end

    $display("[TB] random traffic");
    rsel = 1'b0; rd = '0;
    for (int i = 0; i < 500; i++) begin
      if (!stalled) begin
        rv   = ($urandom_range(0, 9) < 7);
        rsel = 1'($urandom_range(0, 1));
        rd   = 12'($urandom);
      end else begin
        rv = 1'b1;
      end
      rf = ($urandom_range(0, 29) == 0);
      rs = ($urandom_range(0, 99) != 0);
      applyStimulus(rv, rsel, rd, rf, rs);
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
